spi_tx_sequencer: RTL and testbench

SPI_TX_SEQUENCER -- requirements
Module: spi_tx_sequencer

---
 rtl/spi_tx_sequencer.sv | 151 +++++++++++++++
 tb/tb_spi_tx_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_sequencer.sv
// SPI transmit sequencer.
// Buffers user bytes in a small TX FIFO and drives an SPI master core (SPI_TOP) one byte at a
// time. Slave select stays asserted across back-to-back bytes. Each completed byte returns the
// received byte on rx_data_o / rx_valid_o. A watchdog aborts a transfer that never completes.
//
// Ports:
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   tx_data_i/valid_i    user byte stream; tx_ready_o high while the FIFO has space
//   cfg_spcr_i, cfg_br_i mode and baud configuration, latched at the start of each burst
//   spif_i               transfer-complete flag from the SPI core
//   spi_rx_data_i        byte received by the SPI core, valid while spif_i is high
//   spdr_from_user_o     byte presented to the SPI core
//   spcr_in_o            latched mode bits with the enable bit (bit 6) driven by the FSM
//   spibr_in_o           latched baud divisor
//   ss_master_o          slave select, active low
//   rx_data_o/valid_o    captured received byte and its one-cycle strobe
//   busy_o               high whenever a burst is in progress
//   err_o                one-cycle strobe when the watchdog aborts a transfer
module spi_tx_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic [7:0] cfg_spcr_i,
  input  logic [7:0] cfg_br_i,
  input  logic       spif_i,
  input  logic [7:0] spi_rx_data_i,
  output logic [7:0] spdr_from_user_o,
  output logic [7:0] spcr_in_o,
  output logic [7:0] spibr_in_o,
  output logic       ss_master_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StXfer, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [6:0]      mode_q;      // {spcr[7], spcr[5:0]}; the enable bit comes from the FSM
  logic [7:0]      br_q;
  logic [7:0]      spdr_q;
  logic [7:0]      rx_data_q;
  logic            spif_q;
  logic            err_q;
  logic [WdW-1:0]  wd_q, wd_d;

  logic push, pop, spif_rise, wd_abort, cfg_latch, spe;
  logic unused_spe_cfg;

  assign unused_spe_cfg = cfg_spcr_i[6];

  assign tx_ready_o = (count_q != CntFull);
  assign push       = tx_valid_i & tx_ready_o;
  // Completion is a rising edge of the flag, so a flag still high from before XFER is ignored.
  assign spif_rise  = spif_i & ~spif_q;
  assign wd_abort   = (state_q == StXfer) & ~spif_rise & (wd_q == WdLast);
  assign pop        = (state_q == StDone) | wd_abort;
  assign cfg_latch  = (state_q == StIdle) & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (count_q != '0) state_d = StLoad;
      StLoad: state_d = StXfer;
      StXfer: begin
        if (spif_rise) begin
          state_d = StDone;
        end else if (wd_abort) begin
          state_d = StIdle;
        end
      end
      // count_d already accounts for this cycle's pop and any concurrent push.
      StDone:  state_d = (count_d != '0) ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Watchdog counts only while remaining in XFER, so it restarts at zero for every byte.
  assign wd_d = ((state_q == StXfer) && (state_d == StXfer)) ? wd_q + WdW'(1) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mode_q    <= '0;
      br_q      <= '0;
      spdr_q    <= '0;
      rx_data_q <= '0;
      spif_q    <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      spif_q  <= spif_i;
      err_q   <= wd_abort;
      wd_q    <= wd_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (cfg_latch) begin
        mode_q <= {cfg_spcr_i[7], cfg_spcr_i[5:0]};
        br_q   <= cfg_br_i;
      end
      if (state_q == StLoad) spdr_q <= mem_q[rd_ptr_q];
      if ((state_q == StXfer) && spif_rise) rx_data_q <= spi_rx_data_i;
    end
  end

  // FIFO storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  assign spe              = (state_q == StXfer);
  assign ss_master_o      = (state_q == StIdle);
  assign busy_o           = (state_q != StIdle);
  assign rx_valid_o       = (state_q == StDone);
  assign err_o            = err_q;
  assign rx_data_o        = rx_data_q;
  assign spibr_in_o       = br_q;
  assign spcr_in_o        = {mode_q[6], spe, mode_q[5:0]};
  // In LOAD the head is shown directly; from XFER on, the copy taken in LOAD is held.
  assign spdr_from_user_o = (state_q == StLoad) ? mem_q[rd_ptr_q] : spdr_q;

endmodule

// File: tb/tb_spi_tx_sequencer.sv
module tb_spi_tx_sequencer;
  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 16;

  logic       clk, rst_n;
  logic [7:0] tx_data, cfg_spcr, cfg_br, spi_rx, spdr, spcr_in, spibr_in, rx_data;
  logic       tx_valid, tx_ready, spif, ss_master, rx_valid, busy, err;

  int n_checks = 0;
  int n_fail   = 0;
  int ss_glitch = 0;
  bit mon_ss = 0;

  spi_tx_sequencer #(.DEPTH(Depth), .TIMEOUT(Timeout)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .cfg_spcr_i(cfg_spcr), .cfg_br_i(cfg_br),
    .spif_i(spif), .spi_rx_data_i(spi_rx),
    .spdr_from_user_o(spdr), .spcr_in_o(spcr_in), .spibr_in_o(spibr_in),
    .ss_master_o(ss_master), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Waits (bounded) for the enable bit, then completes one byte with a SPIF pulse.
  task automatic xfer(input logic [7:0] exp_tx, input logic [7:0] rx, input int delay,
                      input int exp_br);
    int t;
    t = 0;
    while (spcr_in[6] !== 1'b1 && t < 40) begin
      step();
      t++;
      if (mon_ss && ss_master !== 1'b0) ss_glitch++;
    end
    chk1("xfer_started", t < 40, 1'b1);
    chk8("xfer_spdr", spdr, exp_tx);
    repeat (delay) step();
    chk1("xfer_spe_held", spcr_in[6], 1'b1);
    if (exp_br >= 0) chk8("xfer_spibr", spibr_in, 8'(exp_br));
    spif = 1'b1;
    spi_rx = rx;
    step();
    spif = 1'b0;
    chk1("xfer_rx_valid", rx_valid, 1'b1);
    chk8("xfer_rx_data", rx_data, rx);
    chk1("xfer_done_ss_low", ss_master, 1'b0);
  endtask

  task automatic wait_spe(input string name);
    int t;
    t = 0;
    while (spcr_in[6] !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    chk1(name, t < 40, 1'b1);
  endtask

  typedef struct {
    logic tv; logic [7:0] td; logic sf; logic [7:0] srx;
    logic e_ss; logic e_spe; logic e_busy; logic e_txr; logic e_rxv;
    logic [7:0] e_rxd; logic [7:0] e_spcr; logic [7:0] e_spibr;
    logic c_spdr; logic [7:0] e_spdr;
  } vec_t;

  vec_t tbl [6];

  logic [7:0] q [$];
  int pushes, rx_count, arm, cnt_a, cnt_b, cnt_c;
  bit push_pend, pop_pend, resp_sent;
  logic [7:0] push_byte, exp_rx;

  initial begin
    rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0; cfg_spcr = 8'h10; cfg_br = 8'h02;
    spif = 1'b0; spi_rx = '0;

    // Reset values.
    #2;
    chk1("rst_tx_ready", tx_ready, 1'b1);
    chk1("rst_ss", ss_master, 1'b1);
    chk8("rst_spcr", spcr_in, 8'h00);
    chk8("rst_spibr", spibr_in, 8'h00);
    chk8("rst_spdr", spdr, 8'h00);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single byte, cycle by cycle: IDLE, LOAD, XFER, DONE, IDLE.
    tbl[0] = '{1'b1, 8'hAA, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
               8'h00, 8'h10, 8'h02, 1'b1, 8'hAA};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
               8'h00, 8'h50, 8'h02, 1'b1, 8'hAA};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
               8'h3C, 8'h10, 8'h02, 1'b1, 8'hAA};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               8'h3C, 8'h10, 8'h02, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               8'h3C, 8'h10, 8'h02, 1'b0, 8'h00};
    for (int i = 0; i < 6; i++) begin
      tx_valid = tbl[i].tv; tx_data = tbl[i].td; spif = tbl[i].sf; spi_rx = tbl[i].srx;
      step();
      chk1("vec_ss", ss_master, tbl[i].e_ss);
      chk1("vec_spe", spcr_in[6], tbl[i].e_spe);
      chk1("vec_busy", busy, tbl[i].e_busy);
      chk1("vec_tx_ready", tx_ready, tbl[i].e_txr);
      chk1("vec_rx_valid", rx_valid, tbl[i].e_rxv);
      chk8("vec_rx_data", rx_data, tbl[i].e_rxd);
      chk8("vec_spcr", spcr_in, tbl[i].e_spcr);
      chk8("vec_spibr", spibr_in, tbl[i].e_spibr);
      if (tbl[i].c_spdr) chk8("vec_spdr", spdr, tbl[i].e_spdr);
    end

    // SPIF already high on XFER entry is not a completion.
    spif = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h66;
    step();
    tx_valid = 1'b0;
    wait_spe("lvl_started");
    cnt_a = 0;
    repeat (3) begin step(); if (rx_valid) cnt_a++; end
    chk1("lvl_no_done", cnt_a == 0, 1'b1);
    chk1("lvl_still_xfer", spcr_in[6], 1'b1);
    spif = 1'b0;
    step();
    spif = 1'b1; spi_rx = 8'hC3;
    step();
    spif = 1'b0;
    chk1("lvl_rx_valid", rx_valid, 1'b1);
    chk8("lvl_rx_data", rx_data, 8'hC3);
    step();
    chk1("lvl_idle_ss", ss_master, 1'b1);

    // Burst of three with slave select held low throughout.
    tx_valid = 1'b1; tx_data = 8'h11; step();
    tx_data = 8'h22; step();
    tx_data = 8'h33; step();
    tx_valid = 1'b0;
    mon_ss = 1;
    xfer(8'h11, 8'hE1, 2, -1);
    xfer(8'h22, 8'hE2, 0, -1);
    xfer(8'h33, 8'hE3, 3, -1);
    mon_ss = 0;
    chk1("burst_ss_never_high", ss_glitch == 0, 1'b1);
    step();
    chk1("burst_busy_fall", busy, 1'b0);
    chk1("burst_ss_high", ss_master, 1'b1);

    // FIFO full: fifth byte held off until the first DONE.
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 8'hA0 + 8'(i);
      step();
      if (i == 2) chk1("full_ready_at_3", tx_ready, 1'b1);
    end
    chk1("full_ready_low", tx_ready, 1'b0);
    tx_data = 8'hA4;
    chk8("full_spdr_head", spdr, 8'hA0);
    repeat (3) begin step(); chk1("full_ready_held", tx_ready, 1'b0); end
    spif = 1'b1; spi_rx = 8'h5A;
    step();
    spif = 1'b0;
    chk1("full_done", rx_valid, 1'b1);
    chk8("full_rx_data", rx_data, 8'h5A);
    chk1("full_ready_in_done", tx_ready, 1'b0);
    step();
    chk1("full_ready_rise", tx_ready, 1'b1);
    step();
    tx_valid = 1'b0;
    chk1("full_ready_refill", tx_ready, 1'b0);
    xfer(8'hA1, 8'h01, 1, -1);
    xfer(8'hA2, 8'h02, 1, -1);
    xfer(8'hA3, 8'h03, 1, -1);
    xfer(8'hA4, 8'h04, 1, -1);
    step();
    chk1("full_drained", busy, 1'b0);

    // Watchdog abort: err 16 cycles after XFER entry.
    tx_valid = 1'b1; tx_data = 8'h55;
    step();
    tx_valid = 1'b0;
    wait_spe("to_started");
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (err) cnt_a++;
      if (!spcr_in[6]) cnt_b++;
      if (rx_valid) cnt_c++;
    end
    chk1("to_no_early_err", cnt_a == 0, 1'b1);
    chk1("to_stays_xfer", cnt_b == 0, 1'b1);
    step();
    chk1("to_err", err, 1'b1);
    chk1("to_ss", ss_master, 1'b1);
    chk1("to_spe", spcr_in[6], 1'b0);
    chk1("to_busy", busy, 1'b0);
    chk1("to_no_rx_valid", rx_valid == 1'b0 && cnt_c == 0, 1'b1);
    chk1("to_ready", tx_ready, 1'b1);
    step();
    chk1("to_err_pulse", err, 1'b0);
    repeat (3) step();
    chk1("to_fifo_empty", busy, 1'b0);

    // Config latched only at burst start.
    cfg_br = 8'h02;
    tx_valid = 1'b1; tx_data = 8'h77; step();
    tx_data = 8'h88; step();
    tx_valid = 1'b0;
    wait_spe("cfg_started");
    chk8("cfg_br_first", spibr_in, 8'h02);
    cfg_br = 8'h08;
    xfer(8'h77, 8'h17, 2, 2);
    xfer(8'h88, 8'h18, 1, 2);
    step();
    chk1("cfg_idle", busy, 1'b0);
    tx_valid = 1'b1; tx_data = 8'h99; step();
    tx_valid = 1'b0;
    xfer(8'h99, 8'h19, 1, 8);
    step();

    // Randomized traffic against a queue model.
    pushes = 0; rx_count = 0; arm = -1; push_pend = 0; pop_pend = 0; resp_sent = 0;
    q.delete();
    for (int cyc = 0; cyc < 450; cyc++) begin
      push_pend = tx_valid && tx_ready;
      push_byte = tx_data;
      step();
      if (push_pend) begin q.push_back(push_byte); pushes++; end
      if (pop_pend) begin void'(q.pop_front()); pop_pend = 0; end
      chk1("rnd_tx_ready", tx_ready, q.size() != Depth);
      chk1("rnd_err", err, 1'b0);
      if (rx_valid) begin
        chk1("rnd_rx_expected", resp_sent, 1'b1);
        chk8("rnd_rx_data", rx_data, exp_rx);
        pop_pend = 1;
        rx_count++;
        resp_sent = 0;
      end else if (busy && !ss_master) begin
        if (q.size() == 0) chk1("rnd_model_nonempty", 1'b0, 1'b1);
        else chk8("rnd_spdr", spdr, q[0]);
      end
      if (spif) begin
        spif = 1'b0;
      end else if (spcr_in[6] && !resp_sent) begin
        if (arm < 0) arm = int'($urandom_range(0, 10));
        if (arm == 0) begin
          spif = 1'b1; spi_rx = 8'($urandom); exp_rx = spi_rx; resp_sent = 1; arm = -1;
        end else begin
          arm--;
        end
      end
      tx_valid = (cyc < 350) && ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
    end
    tx_valid = 1'b0;
    if (pop_pend) void'(q.pop_front());
    chk1("rnd_all_sent", q.size() == 0, 1'b1);
    chk1("rnd_rx_count", rx_count == pushes, 1'b1);
    chk1("rnd_idle", busy, 1'b0);

    // Reset during byte 2 of a 3-byte burst.
    tx_valid = 1'b1; tx_data = 8'hC1; step();
    tx_data = 8'hC2; step();
    tx_data = 8'hC3; step();
    tx_valid = 1'b0;
    xfer(8'hC1, 8'h21, 1, -1);
    wait_spe("rst_mid_started");
    chk8("rst_mid_spdr", spdr, 8'hC2);
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_mid_ss", ss_master, 1'b1);
    chk8("rst_mid_spcr", spcr_in, 8'h00);
    chk8("rst_mid_spibr", spibr_in, 8'h00);
    chk8("rst_mid_spdr0", spdr, 8'h00);
    chk8("rst_mid_rx_data", rx_data, 8'h00);
    chk1("rst_mid_rx_valid", rx_valid, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_err", err, 1'b0);
    chk1("rst_mid_ready", tx_ready, 1'b1);
    step();
    rst_n = 1'b1;
    cnt_a = 0;
    repeat (4) begin step(); if (busy || rx_valid || err || !tx_ready) cnt_a++; end
    chk1("rst_mid_empty_idle", cnt_a == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
